// File: rtl/selevy_gpout_pkg.sv
// Shared register map, mode encodings and CTRL field layout for the
// selevy general-purpose output block.
package selevy_gpout_pkg;

  localparam logic [3:0] GPOUT_CTRL = 4'd8;
  localparam logic [3:0] GPOUT_DIV  = 4'd9;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } wr_req_t;

  // Bit offset of MODE[ch] inside CTRL.
  function automatic int ctrl_mode_pos(input int ch);
    return CTRL_MODE_LSB + 2 * ch;
  endfunction

endpackage

// File: rtl/selevy_clkdiv.sv
// Programmable divider: out_clk half period is div+1 CLK cycles; tick marks
// the cycle in which out_clk has just risen.
module selevy_clkdiv #(
  parameter int DIVW = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            div_we,
  output logic            out_clk,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            out_clk_q, out_clk_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    out_clk_d = out_clk_q;
    tick_d    = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      out_clk_d = 1'b0;
    end else if (div_we) begin
      // Restart the period on a DIV rewrite so a smaller DIV never wraps.
      cnt_d = '0;
    end else if (cnt_q == div) begin
      cnt_d     = '0;
      out_clk_d = ~out_clk_q;
      tick_d    = ~out_clk_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q     <= '0;
      out_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_clk_q <= out_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign out_clk = out_clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/selevy_gpout.sv
// NCH memory-mapped output channels (static / blink / rotate) stepped by a
// programmable divided clock, with a combinational register read port.
module selevy_gpout
  import selevy_gpout_pkg::*;
#(
  parameter int GW   = 4,
  parameter int NCH  = 2,
  parameter int DIVW = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NCH*GW-1:0] gout,
  output logic              out_clk,
  output logic              tick
);

  wr_req_t req;
  assign req = '{we: we, addr: addr, wdata: wdata};

  logic wr_ctrl, wr_div;
  assign wr_ctrl = req.we && (req.addr == GPOUT_CTRL);
  assign wr_div  = req.we && (req.addr == GPOUT_DIV);

  logic                 en_q, en_d;
  logic [NCH-1:0][1:0]  mode_q, mode_d;
  logic [DIVW-1:0]      div_q, div_d;
  logic [NCH-1:0][GW-1:0] data_all;
  logic                 tick_w;

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    div_d  = div_q;
    if (wr_ctrl) begin
      en_d = req.wdata[CTRL_EN_BIT];
      for (int i = 0; i < NCH; i++) mode_d[i] = req.wdata[ctrl_mode_pos(i) +: 2];
    end
    if (wr_div) div_d = req.wdata[DIVW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      en_q   <= 1'b0;
      mode_q <= '0;
      div_q  <= '0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
      div_q  <= div_d;
    end
  end

  selevy_clkdiv #(.DIVW(DIVW)) u_clkdiv (
    .CLK     (CLK),
    .reset   (reset),
    .en      (en_q),
    .div     (div_q),
    .div_we  (wr_div),
    .out_clk (out_clk),
    .tick    (tick_w)
  );
  assign tick = tick_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [GW-1:0] data_q, data_d, gout_q, gout_d;
    logic          phase_q, phase_d;
    logic          wr_data, load;

    assign wr_data = req.we && (req.addr == 4'(i));
    // A data write or a mode change reloads the visible value and beats any tick.
    assign load    = wr_data || (wr_ctrl && (mode_d[i] != mode_q[i]));

    always_comb begin
      data_d  = wr_data ? req.wdata[GW-1:0] : data_q;
      gout_d  = gout_q;
      phase_d = phase_q;
      if (load) begin
        gout_d  = data_d;
        phase_d = 1'b1;
      end else begin
        case (mode_e'(mode_q[i]))
          MODE_BLINK: if (tick_w) begin
            phase_d = ~phase_q;
            gout_d  = phase_q ? '0 : data_q;
          end
          MODE_ROTATE: if (tick_w) gout_d = (gout_q << 1) | (gout_q >> (GW - 1));
          default: gout_d = data_q;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        data_q  <= '0;
        gout_q  <= '0;
        phase_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        gout_q  <= gout_d;
        phase_q <= phase_d;
      end
    end

    assign data_all[i]       = data_q;
    assign gout[i*GW +: GW]  = gout_q;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req.addr == 4'(i)) rdata[GW-1:0] = data_all[i];
    end
    if (req.addr == GPOUT_CTRL) begin
      rdata[CTRL_EN_BIT] = en_q;
      for (int i = 0; i < NCH; i++) rdata[ctrl_mode_pos(i) +: 2] = mode_q[i];
    end
    if (req.addr == GPOUT_DIV) rdata[DIVW-1:0] = div_q;
  end

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^req.wdata;

endmodule

// File: tb/tb_selevy_gpout.sv
// Self-checking bench for selevy_gpout: register table, divider timing,
// rotate/blink stepping, write-vs-tick priority, DIV rewrite and reset.
module tb_selevy_gpout;

  localparam int GW = 4, NCH = 2, DIVW = 8;

  logic              CLK = 1'b0;
  logic              reset, we;
  logic [3:0]        addr;
  logic [31:0]       wdata, rdata;
  logic [NCH*GW-1:0] gout;
  logic              out_clk, tick;

  always #5 CLK = ~CLK;

  selevy_gpout #(.GW(GW), .NCH(NCH), .DIVW(DIVW)) dut (
    .CLK(CLK), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .gout(gout), .out_clk(out_clk), .tick(tick)
  );

  typedef struct {
    logic [7:0]  g;
    logic        c;
    logic        t;
    logic        rd_en;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [7:0]  g;
    logic [31:0] rd;
  } vec_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare once the edge has passed.
  task automatic step(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [7:0] g, input logic c, input logic t,
                      input logic rd_en, input logic [31:0] rd, input string nm);
    exp_t  e;
    string n;
    we = w; addr = a; wdata = d;
    e.g = g; e.c = c; e.t = t; e.rd_en = rd_en; e.rd = rd;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    n = nm_q.pop_front();
    chk($sformatf("%s.gout", n), 32'(gout), 32'(e.g));
    chk($sformatf("%s.out_clk", n), 32'(out_clk), 32'(e.c));
    chk($sformatf("%s.tick", n), 32'(tick), 32'(e.t));
    if (e.rd_en) chk($sformatf("%s.rdata", n), rdata, e.rd);
    we = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
    we = 1'b0; addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    step(1'b0, 4'd0, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0, nm);
    reset = 1'b0;
    rd_chk(4'd0, 32'd0, {nm, ".rd0"});
    rd_chk(4'd8, 32'd0, {nm, ".rd8"});
    rd_chk(4'd9, 32'd0, {nm, ".rd9"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic [7:0] g;
    logic       c, t;

    tbl[0] = '{1'b1, 4'd0,  32'h0000000A, 8'h0A, 32'h0A};
    tbl[1] = '{1'b1, 4'd1,  32'h00000003, 8'h3A, 32'h03};
    tbl[2] = '{1'b0, 4'd1,  32'h00000000, 8'h3A, 32'h03};
    tbl[3] = '{1'b1, 4'd0,  32'hFFFFFFF5, 8'h35, 32'h05};
    tbl[4] = '{1'b1, 4'd2,  32'h0000000F, 8'h35, 32'h00};
    tbl[5] = '{1'b1, 4'd15, 32'hFFFFFFFF, 8'h35, 32'h00};
    tbl[6] = '{1'b1, 4'd9,  32'h00010203, 8'h35, 32'h03};
    tbl[7] = '{1'b1, 4'd8,  32'h0000001E, 8'h35, 32'h1E};
    tbl[8] = '{1'b1, 4'd8,  32'hFFFFFFE0, 8'h35, 32'h00};
    tbl[9] = '{1'b0, 4'd0,  32'h00000000, 8'h35, 32'h05};

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    step(1'b0, 4'd0, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0, "rst0");
    do_reset("rst1");

    // Register writes and reads with the divider disabled.
    for (int i = 0; i < 10; i++)
      step(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].g, 1'b0, 1'b0, 1'b1, tbl[i].rd,
           $sformatf("tbl%0d", i));
    rd_chk(4'd1, 32'd3, "tbl.rd1");

    // DIV=2: half period 3, tick once per 6 CLK.
    step(1'b1, 4'd9, 32'd2, 8'h35, 1'b0, 1'b0, 1'b1, 32'd2, "t2.div");
    step(1'b1, 4'd8, 32'd1, 8'h35, 1'b0, 1'b0, 1'b1, 32'd1, "t2.ctrl");
    for (int k = 1; k <= 18; k++)
      step(1'b0, 4'd0, 32'd0, 8'h35, 1'(((k / 3) % 2) == 1), 1'(k % 6 == 3), 1'b0, 32'd0,
           $sformatf("t2.k%0d", k));
    step(1'b1, 4'd8, 32'd0, 8'h35, 1'b0, 1'b0, 1'b1, 32'd0, "t2.off");
    for (int k = 0; k < 10; k++)
      step(1'b0, 4'd0, 32'd0, 8'h35, 1'b0, 1'b0, 1'b0, 32'd0, $sformatf("t2.idle%0d", k));

    // Rotate on channel 0 with DIV=0.
    do_reset("rst2");
    step(1'b1, 4'd0, 32'd1, 8'h01, 1'b0, 1'b0, 1'b1, 32'd1, "t3.data");
    step(1'b1, 4'd9, 32'd0, 8'h01, 1'b0, 1'b0, 1'b1, 32'd0, "t3.div");
    step(1'b1, 4'd8, 32'd5, 8'h01, 1'b0, 1'b0, 1'b1, 32'd5, "t3.ctrl");
    for (int k = 1; k <= 11; k++) begin
      g = 8'(4'b0001 << ((k / 2) % 4));
      step(1'b0, 4'd0, 32'd0, g, 1'(k % 2), 1'(k % 2), 1'b0, 32'd0, $sformatf("t3.k%0d", k));
    end

    // Reset while rotating with out_clk high.
    do_reset("t6.rst");

    // Blink on channel 1; data write lands on a tick cycle at k=6.
    step(1'b1, 4'd1, 32'hF, 8'hF0, 1'b0, 1'b0, 1'b1, 32'hF, "t4.data");
    step(1'b1, 4'd9, 32'd0, 8'hF0, 1'b0, 1'b0, 1'b1, 32'd0, "t4.div");
    step(1'b1, 4'd8, 32'd9, 8'hF0, 1'b0, 1'b0, 1'b1, 32'd9, "t4.ctrl");
    for (int k = 1; k <= 12; k++) begin
      if (k < 6) g = (((k / 2) % 2) == 0) ? 8'hF0 : 8'h00;
      else       g = ((((k - 6) / 2) % 2) == 0) ? 8'h50 : 8'h00;
      step(1'(k == 6), 4'd1, 32'd5, g, 1'(k % 2), 1'(k % 2), 1'b0, 32'd0,
           $sformatf("t4.k%0d", k));
    end
    rd_chk(4'd1, 32'd5, "t4.rd1");

    // DIV 5 -> 1 with counter at 4, then disable while out_clk is high.
    do_reset("rst3");
    step(1'b1, 4'd9, 32'd5, 8'h00, 1'b0, 1'b0, 1'b1, 32'd5, "t5.div");
    step(1'b1, 4'd8, 32'd1, 8'h00, 1'b0, 1'b0, 1'b1, 32'd1, "t5.ctrl");
    for (int k = 1; k <= 20; k++) begin
      c = (k == 7 || k == 8 || k == 11 || k == 12);
      t = (k == 7 || k == 11);
      if (k == 5)       step(1'b1, 4'd9, 32'd1, 8'h00, c, t, 1'b1, 32'd1, "t5.k5");
      else if (k == 12) step(1'b1, 4'd8, 32'd0, 8'h00, c, t, 1'b1, 32'd0, "t5.k12");
      else              step(1'b0, 4'd0, 32'd0, 8'h00, c, t, 1'b0, 32'd0, $sformatf("t5.k%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/selevy_gpout.md
Name: selevy_gpout

Overview:
- Parametrised successor to the fixed 4-bit general output port and output clock of the selevy core.
- Provides NCH memory-mapped output channels of GW bits each, plus a programmable clock divider that drives out_clk.
- Each channel has a per-channel mode: static, blink or rotate, stepped by the divided clock.
- Sits on the core's store path (write strobe, address, data) and drives the top-level gout and out_clk pins.

Parameters:
- GW, 4: bits per output channel.
- NCH, 2: number of output channels (1..8).
- DIVW, 8: width of the divider count register.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  register write strobe, single cycle.
- addr  in  4  register address.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr.
- gout  out  NCH*GW  channel outputs; channel i occupies bits [i*GW +: GW].
- out_clk  out  1  divided output clock.
- tick  out  1  one-CLK pulse coincident with each out_clk low-to-high transition.

Behaviour:
- Reset: synchronous and active-high. While reset is high at a CLK edge, the following are all 0: data regs, mode bits, clk_en, DIV, divider counter, out_clk, tick, gout.
- Register map:
  - addr 0..NCH-1: DATA[i], lower GW bits of wdata.
  - addr 8: CTRL. Bit 0 is clk_en. Bits [2i+2:2i+1] are MODE[i].
  - addr 9: DIV, lower DIVW bits of wdata.
  - All other addresses: writes are ignored and reads return 0.
- Read path: rdata is zero-extended and combinational; no latency.
- Write latency: a write at edge N is visible on rdata and gout after edge N.
- Divider:
  - With clk_en=1, the counter increments every CLK.
  - When counter==DIV, the counter clears to 0 and out_clk toggles.
  - Half period is DIV+1 CLK cycles. DIV=0 gives out_clk = CLK/2.
  - tick=1 for the cycle following the edge on which out_clk rose.
- clk_en=0: the counter is held at 0 and out_clk is forced to 0 on the next edge. No ticks occur.
- A write to DIV clears the counter at the same edge. out_clk keeps its level.
- Modes, acting on the visible state gout[i]; DATA[i] is the stored value:
  - 00 STATIC: gout[i] = DATA[i] at all times.
  - 01 BLINK: gout[i] alternates between DATA[i] and 0. It toggles at each tick, starting from DATA[i] when the mode is entered.
  - 10 ROTATE: gout[i] rotates left by one bit at each tick. Entering the mode or writing DATA[i] loads gout[i] from DATA[i].
  - 11: reserved, behaves as STATIC.
- Simultaneous events:
  - A write to DATA[i] in the same cycle as a tick: the write wins and the tick step is dropped for that channel.
  - A CTRL write changing MODE[i] in the same cycle as a tick: the new mode's load takes precedence.
- Divider wrap: the counter compares with equality only. If DIV is lowered below the current count, the write clears the counter, so no wrap-around through 2^DIVW occurs.
- Reset mid-operation: all state returns to reset values at the edge. There is no partial-period out_clk glitch beyond the edge itself.

Decomposition:
- Shared defines file:
  - address constants GPOUT_CTRL=8 and GPOUT_DIV=9;
  - mode encodings MODE_STATIC, MODE_BLINK, MODE_ROTATE;
  - CTRL bit positions.
- One sub-module, selevy_clkdiv:
  - Parameter DIVW.
  - Inputs: CLK, reset, en, div, div_we.
  - Outputs: out_clk, tick.
- The channel logic is a generate loop inside selevy_gpout.

Test Plan:
1. Reset then write DATA0=4'b1010 and DATA1=4'b0011, CTRL=0 -> gout=8'b0011_1010 one edge after the last write; out_clk stays 0 and rdata at addr 1 = 3.
2. DIV=2, CTRL=1 -> out_clk toggles every 3 CLK (period 6); tick pulses once per 6 CLK; tick is never asserted while clk_en=0.
3. DATA0=4'b0001, MODE0=ROTATE, DIV=0, clk_en=1 -> gout[3:0] steps 0001, 0010, 0100, 1000, 0001 on consecutive ticks (every 2 CLK).
4. MODE1=BLINK with DATA1=4'b1111 -> gout[7:4] alternates 1111/0000 per tick. A DATA1=4'b0101 write on a tick cycle -> gout[7:4]=0101 next, with no step that cycle.
5. Mid-run DIV rewrite from 5 to 1 at counter=4 -> counter clears and the next toggle occurs 2 CLK later, without waiting for a wrap.
6. Assert reset while rotating with out_clk=1 -> next edge: gout=0, out_clk=0, tick=0, and rdata=0 for addr 0, 8 and 9.
